mem_arbiter: RTL

- Shares the CPU's single-port unified memory between the instruction-fetch port (IF) and the load/store data port (DM) of the 64-bit RISC-V core.
- Accepts one transaction at a time and forwards it to memory. Waits for the memory response, then routes it back to the owning requester.
- Data port has priority. A starvation counter guarantees that fetch makes forward progress.

---
 rtl/cpu_mem_pkg.sv | 21 ++
 rtl/mem_arb_prio.sv | 37 +++
 rtl/mem_arbiter.sv | 123 ++++++++++++
 3 files changed

// File: rtl/cpu_mem_pkg.sv
// Shared types for the unified-memory arbiter of the 64-bit core.
// State, owner encoding and default bus widths.
package cpu_mem_pkg;

    localparam int DEF_ADDR_W     = 64;
    localparam int DEF_DATA_W     = 64;
    localparam int DEF_STARVE_MAX = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } arb_state_e;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_DM = 1'b1
    } owner_e;

endpackage

// File: rtl/mem_arb_prio.sv
// Fetch/data priority pick with a starvation counter that
// forces fetch to win after STARVE_MAX back-to-back data grants.
module mem_arb_prio
    import cpu_mem_pkg::*;
#(
    parameter int STARVE_MAX = DEF_STARVE_MAX
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic if_req,
    input  logic dm_req,
    input  logic grant_en,
    output logic sel_dm
);

    localparam int CNT_W = $clog2(STARVE_MAX + 1);

    logic [CNT_W-1:0] starve_cnt;
    logic             starve_hit;

    assign starve_hit = (starve_cnt == CNT_W'(STARVE_MAX));
    assign sel_dm     = dm_req && !(if_req && starve_hit);

    // Only a fetch grant clears; data grants count only while fetch waits.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            starve_cnt <= '0;
        end else if (grant_en && (if_req || dm_req)) begin
            if (!sel_dm) begin
                starve_cnt <= '0;
            end else if (if_req && !starve_hit) begin
                starve_cnt <= starve_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between instruction fetch and data port.
// One transaction in flight: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
module mem_arbiter
    import cpu_mem_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int STARVE_MAX = DEF_STARVE_MAX
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                if_req_i,
    input  logic [ADDR_W-1:0]   if_addr_i,
    output logic                if_gnt_o,
    output logic                if_rvalid_o,
    output logic [DATA_W-1:0]   if_rdata_o,
    input  logic                dm_req_i,
    input  logic                dm_we_i,
    input  logic [ADDR_W-1:0]   dm_addr_i,
    input  logic [DATA_W-1:0]   dm_wdata_i,
    input  logic [DATA_W/8-1:0] dm_be_i,
    output logic                dm_gnt_o,
    output logic                dm_rvalid_o,
    output logic [DATA_W-1:0]   dm_rdata_o,
    output logic                mem_req_o,
    output logic                mem_we_o,
    output logic [ADDR_W-1:0]   mem_addr_o,
    output logic [DATA_W-1:0]   mem_wdata_o,
    output logic [DATA_W/8-1:0] mem_be_o,
    input  logic                mem_rvalid_i,
    input  logic [DATA_W-1:0]   mem_rdata_i
);

    localparam int BE_W = DATA_W / 8;

    arb_state_e        state;
    owner_e            owner;
    logic              grant_en;
    logic              sel_dm;
    logic              any_req;
    logic [DATA_W-1:0] rsp_data;

    assign grant_en = (state == ST_IDLE) && !rst_i;
    assign any_req  = if_req_i || dm_req_i;
    assign dm_gnt_o = grant_en && sel_dm;
    assign if_gnt_o = grant_en && if_req_i && !sel_dm;
    assign rsp_data = mem_we_o ? '0 : mem_rdata_i;

    mem_arb_prio #(
        .STARVE_MAX (STARVE_MAX)
    ) u_prio (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .if_req   (if_req_i),
        .dm_req   (dm_req_i),
        .grant_en (grant_en),
        .sel_dm   (sel_dm)
    );

    // The command registers double as the latched transaction attributes.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state       <= ST_IDLE;
            owner       <= OWN_IF;
            mem_req_o   <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
            mem_be_o    <= '0;
            if_rvalid_o <= 1'b0;
            dm_rvalid_o <= 1'b0;
            if_rdata_o  <= '0;
            dm_rdata_o  <= '0;
        end else begin
            mem_req_o   <= 1'b0;
            if_rvalid_o <= 1'b0;
            dm_rvalid_o <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (any_req) begin
                        state     <= ST_ISSUE;
                        mem_req_o <= 1'b1;
                        if (sel_dm) begin
                            owner       <= OWN_DM;
                            mem_we_o    <= dm_we_i;
                            mem_addr_o  <= dm_addr_i;
                            mem_wdata_o <= dm_wdata_i;
                            mem_be_o    <= dm_be_i;
                        end else begin
                            owner       <= OWN_IF;
                            mem_we_o    <= 1'b0;
                            mem_addr_o  <= if_addr_i;
                            mem_wdata_o <= '0;
                            mem_be_o    <= {BE_W{1'b1}};
                        end
                    end
                end
                ST_ISSUE: begin
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (mem_rvalid_i) begin
                        state <= ST_RESP;
                        if (owner == OWN_DM) begin
                            dm_rvalid_o <= 1'b1;
                            dm_rdata_o  <= rsp_data;
                        end else begin
                            if_rvalid_o <= 1'b1;
                            if_rdata_o  <= rsp_data;
                        end
                    end
                end
                ST_RESP: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
